uart_tx_fifo: RTL and testbench

Next-generation UART transmitter: parametrised TX FIFO in front of a run-time configurable serialiser.
- Data length 5–9 bits, four parity modes, 1/1.5/2 stop bits, break generation.
- Bit timing derived from an oversampling tick supplied by the baud generator, so stop length 1.5 is exact.
- Sits between the APB register block (push side) and the pad (uart_txd).

---
 rtl/uart_pkg.sv | 49 ++++
 rtl/uart_sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path and its FIFOs.
// Kept separate so a future receiver can reuse the same enums and length limits.
package uart_pkg;

    localparam int DATA_LEN_MIN = 5;
    localparam int DATA_LEN_MAX = 9;

    typedef enum logic [1:0] {
        EVEN  = 2'd0,
        ODD   = 2'd1,
        MARK  = 2'd2,
        SPACE = 2'd3
    } parity_mode_e;

    typedef enum logic [1:0] {
        STOP1   = 2'd0,
        STOP1P5 = 2'd1,
        STOP2   = 2'd2
    } stop_len_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } tx_state_e;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        logic [3:0] res;
        res = len;
        if (len < 4'(DATA_LEN_MIN)) res = 4'(DATA_LEN_MIN);
        if (len > 4'(DATA_LEN_MAX)) res = 4'(DATA_LEN_MAX);
        return res;
    endfunction

    // Encodings 2 and 3 both select two stop bits.
    function automatic stop_len_e decode_stop(input logic [1:0] code);
        stop_len_e res;
        case (code)
            2'd0:    res = STOP1;
            2'd1:    res = STOP1P5;
            default: res = STOP2;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rdPtr_q];
    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: TX FIFO feeding a tick-timed serialiser with configurable
// data length, parity, stop length and line break. Frame settings are frozen at pop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 9,
    parameter int OVS        = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [3:0]        cfg_data_len,
    input  logic              cfg_parity_en,
    input  logic [1:0]        cfg_parity_mode,
    input  logic [1:0]        cfg_stop_len,
    input  logic              cfg_break,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int TCNT_W = $clog2(2 * OVS);
    localparam logic [TCNT_W-1:0] LAST_1   = TCNT_W'(OVS - 1);
    localparam logic [TCNT_W-1:0] LAST_1P5 = TCNT_W'((3 * OVS) / 2 - 1);
    localparam logic [TCNT_W-1:0] LAST_2   = TCNT_W'(2 * OVS - 1);

    tx_state_e          state_q, state_d;
    logic [TCNT_W-1:0]  tickCnt_q, tickCnt_d;
    logic [3:0]         bitIdx_q, bitIdx_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [3:0]         len_q, len_d;
    logic               parEn_q, parEn_d;
    logic               parBit_q, parBit_d;
    stop_len_e          stopLen_q, stopLen_d;
    logic               fromBreak_q, fromBreak_d;
    logic               txd_q, txd_d;
    logic               done_q, done_d;

    logic               popReq;
    logic [DATA_W-1:0]  popData;
    logic [3:0]         lenNew;
    logic               popParity;
    logic [TCNT_W-1:0]  lastCnt;
    logic               bitEnd;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (s_valid),
        .push_data_i (s_data),
        .pop_i       (popReq),
        .pop_data_o  (popData),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign s_ready  = !fifo_full;
    assign uart_txd = txd_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != IDLE);

    // Length and parity of the word at the FIFO head, evaluated against live config.
    always_comb begin
        logic acc;
        lenNew = clamp_len(cfg_data_len);
        if (int'(lenNew) > DATA_W) lenNew = 4'(DATA_W);
        acc = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(lenNew)) acc = acc ^ popData[i];
        end
        case (parity_mode_e'(cfg_parity_mode))
            EVEN:    popParity = acc;
            ODD:     popParity = ~acc;
            MARK:    popParity = 1'b1;
            default: popParity = 1'b0;
        endcase
    end

    always_comb begin
        lastCnt = LAST_1;
        if (state_q == STOP) begin
            if (fromBreak_q) begin
                lastCnt = LAST_2;
            end else begin
                case (stopLen_q)
                    STOP1:   lastCnt = LAST_1;
                    STOP1P5: lastCnt = LAST_1P5;
                    default: lastCnt = LAST_2;
                endcase
            end
        end
    end

    assign bitEnd = tick && (tickCnt_q == lastCnt);

    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        len_d       = len_q;
        parEn_d     = parEn_q;
        parBit_d    = parBit_q;
        stopLen_d   = stopLen_q;
        fromBreak_d = fromBreak_q;
        done_d      = 1'b0;
        popReq      = 1'b0;

        if ((state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) && tick) begin
            tickCnt_d = bitEnd ? '0 : tickCnt_q + TCNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tickCnt_d = '0;
                if (cfg_break) begin
                    state_d = BREAK;
                end else if (!fifo_empty) begin
                    popReq      = 1'b1;
                    shift_d     = popData;
                    len_d       = lenNew;
                    parEn_d     = cfg_parity_en;
                    parBit_d    = popParity;
                    stopLen_d   = decode_stop(cfg_stop_len);
                    fromBreak_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d = shift_q >> 1;
                    if (bitIdx_q == len_q - 4'd1) begin
                        state_d = parEn_q ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bitEnd) state_d = STOP;
            end
            STOP: begin
                if (bitEnd) begin
                    done_d      = !fromBreak_q;
                    fromBreak_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            BREAK: begin
                tickCnt_d = '0;
                if (!cfg_break) begin
                    fromBreak_d = 1'b1;
                    state_d     = STOP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is a registered function of the current state, so it trails by one clk.
    always_comb begin
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = parBit_q;
            BREAK:   txd_d = 1'b0;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            len_q       <= 4'(DATA_LEN_MIN);
            parEn_q     <= 1'b0;
            parBit_q    <= 1'b0;
            stopLen_q   <= STOP1;
            fromBreak_q <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            parEn_q     <= parEn_d;
            parBit_q    <= parBit_d;
            stopLen_q   <= stopLen_d;
            fromBreak_q <= fromBreak_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame formats, FIFO fill, break, flush and async reset.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 9;
    localparam int OVS   = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [3:0]    cfg_data_len = 4'd8;
    logic          cfg_parity_en = 1'b0;
    logic [1:0]    cfg_parity_mode = 2'd0;
    logic [1:0]    cfg_stop_len = 2'd0;
    logic          cfg_break = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          uart_txd;
    logic          tx_busy;
    logic          tx_done;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int doneCount   = 0;
    int lastDoneCyc = 0;
    bit tickSlow    = 1'b0;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .OVS(OVS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cfg_data_len(cfg_data_len), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_mode(cfg_parity_mode), .cfg_stop_len(cfg_stop_len),
        .cfg_break(cfg_break), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) tick = tickSlow ? ~tick : 1'b1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            doneCount++;
            lastDoneCyc = cyc;
        end
    end

    task automatic pushWord(input logic [DW-1:0] d, output int pc);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        pc = cyc;
    endtask

    // Waits for a start-bit edge, then samples each bit at its centre (tick every clk).
    task automatic captureFrame(input int nBits, output logic [15:0] bits, output int fallCyc, output bit ok);
        int n;
        n = 0;
        bits = '0;
        fallCyc = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_txd !== 1'b0 && n < 5000);
        ok = (uart_txd === 1'b0);
        if (ok) begin
            fallCyc = cyc;
            repeat (8) @(negedge clk);
            bits[0] = uart_txd;
            for (int k = 1; k < nBits; k++) begin
                repeat (16) @(negedge clk);
                bits[k] = uart_txd;
            end
        end
    endtask

    task automatic waitDone(input int target, output bit ok);
        int n;
        n = 0;
        while (doneCount < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = (doneCount >= target);
    endtask

    task automatic quietLows(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        assertCount++; if (uart_txd !== 1'b1)   begin failCount++; $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd); end
        assertCount++; if (tx_busy !== 1'b0)    begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
        assertCount++; if (tx_done !== 1'b0)    begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
        assertCount++; if (fifo_count !== '0)   begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        assertCount++; if (fifo_empty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); end
        assertCount++; if (fifo_full !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
        assertCount++; if (s_ready !== 1'b1)    begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_8e2();
        int pc, fall, prev;
        logic [15:0] bits;
        bit ok, dok;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b1; cfg_parity_mode = 2'd0; cfg_stop_len = 2'd2;
        prev = doneCount;
        pushWord(9'h00F, pc);
        captureFrame(12, bits, fall, ok);
        assertCount++; if (!ok || bits !== 16'h0C1E) begin failCount++; $display("[TB] FAIL 8e2_bits: got %h expected 0c1e", bits); end
        assertCount++; if (fall - pc !== 2) begin failCount++; $display("[TB] FAIL 8e2_start_latency: got %0d expected 2", fall - pc); end
        waitDone(prev + 1, dok);
        assertCount++; if (!dok || lastDoneCyc - pc !== 193) begin failCount++; $display("[TB] FAIL 8e2_done_time: got %0d expected 193", lastDoneCyc - pc); end
    endtask

    task automatic test_5o15();
        int pc, fall, prev;
        logic [15:0] bits;
        bit ok, dok;
        cfg_data_len = 4'd5; cfg_parity_en = 1'b1; cfg_parity_mode = 2'd1; cfg_stop_len = 2'd1;
        prev = doneCount;
        // Bits 5..7 are set to show that parity ignores bits beyond the length.
        pushWord(9'h0FB, pc);
        fork
            captureFrame(8, bits, fall, ok);
            begin
                repeat (30) @(negedge clk);
                cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop_len = 2'd2;
            end
        join
        assertCount++; if (!ok || bits !== 16'h00F6) begin failCount++; $display("[TB] FAIL 5o15_bits: got %h expected 00f6", bits); end
        waitDone(prev + 1, dok);
        assertCount++; if (!dok || lastDoneCyc - pc !== 137) begin failCount++; $display("[TB] FAIL 5o15_done_time: got %0d expected 137", lastDoneCyc - pc); end
    endtask

    task automatic test_slow_tick();
        int pc, prev, dt;
        bit dok;
        // Length 3 clamps to 5: 112 ticks at one tick per two clocks.
        cfg_data_len = 4'd3; cfg_parity_en = 1'b0; cfg_stop_len = 2'd0;
        tickSlow = 1'b1;
        prev = doneCount;
        pushWord(9'h000, pc);
        waitDone(prev + 1, dok);
        dt = lastDoneCyc - pc;
        assertCount++; if (!dok || dt < 224 || dt > 225) begin failCount++; $display("[TB] FAIL slow_tick_done_time: got %0d expected 224..225", dt); end
        tickSlow = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_fifo_fill();
        int prev, fall, prevFall, lows;
        logic [15:0] bits, exp;
        logic [7:0] w;
        bit ok;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop_len = 2'd0;
        cfg_break = 1'b1;
        repeat (4) @(negedge clk);
        assertCount++; if (uart_txd !== 1'b0) begin failCount++; $display("[TB] FAIL fill_break_idle: got %b expected 0", uart_txd); end
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) begin
                assertCount++; if (s_ready !== 1'b0 || fifo_full !== 1'b1) begin failCount++; $display("[TB] FAIL fill_ready_full: ready %b full %b expected 0 1", s_ready, fifo_full); end
            end
            s_valid = 1'b1;
            s_data  = {1'b0, 8'(i * 37 + 5)};
        end
        @(negedge clk);
        s_valid = 1'b0;
        assertCount++; if (fifo_count !== CW'(16)) begin failCount++; $display("[TB] FAIL fill_count: got %0d expected 16", fifo_count); end
        prev = doneCount;
        cfg_break = 1'b0;
        repeat (4) @(negedge clk);
        prevFall = 0;
        for (int i = 0; i < 16; i++) begin
            w = 8'(i * 37 + 5);
            exp = {6'b0, 1'b1, w, 1'b0};
            captureFrame(10, bits, fall, ok);
            assertCount++; if (!ok || bits !== exp) begin failCount++; $display("[TB] FAIL fill_frame%0d: got %h expected %h", i, bits, exp); end
            if (i > 0) begin
                assertCount++; if (fall - prevFall !== 161) begin failCount++; $display("[TB] FAIL fill_gap%0d: got %0d expected 161", i, fall - prevFall); end
            end
            prevFall = fall;
        end
        quietLows(400, lows);
        assertCount++; if (lows !== 0) begin failCount++; $display("[TB] FAIL fill_no_17th: got %0d low samples expected 0", lows); end
        assertCount++; if (doneCount - prev !== 16) begin failCount++; $display("[TB] FAIL fill_done_count: got %0d expected 16", doneCount - prev); end
    endtask

    task automatic test_break();
        int pc, prev, fall, rc;
        logic [15:0] bits;
        bit ok, dok;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop_len = 2'd0;
        prev = doneCount;
        fork
            captureFrame(10, bits, fall, ok);
            begin
                pushWord(9'h0A5, pc);
                pushWord(9'h03C, pc);
                repeat (60) @(negedge clk);
                cfg_break = 1'b1;
            end
        join
        assertCount++; if (!ok || bits !== 16'h034A) begin failCount++; $display("[TB] FAIL break_frame_intact: got %h expected 034a", bits); end
        repeat (40) @(negedge clk);
        assertCount++; if (uart_txd !== 1'b0 || tx_busy !== 1'b1) begin failCount++; $display("[TB] FAIL break_hold: txd %b busy %b expected 0 1", uart_txd, tx_busy); end
        repeat (60) @(negedge clk);
        assertCount++; if (uart_txd !== 1'b0 || fifo_count !== CW'(1)) begin failCount++; $display("[TB] FAIL break_hold_late: txd %b count %0d expected 0 1", uart_txd, fifo_count); end
        @(negedge clk);
        cfg_break = 1'b0;
        rc = cyc;
        repeat (4) @(negedge clk);
        assertCount++; if (uart_txd !== 1'b1) begin failCount++; $display("[TB] FAIL break_release_mark: got %b expected 1", uart_txd); end
        captureFrame(10, bits, fall, ok);
        assertCount++; if (!ok || fall - rc !== 35) begin failCount++; $display("[TB] FAIL break_mark_len: got %0d expected 35", fall - rc); end
        assertCount++; if (bits !== 16'h0278) begin failCount++; $display("[TB] FAIL break_next_frame: got %h expected 0278", bits); end
        waitDone(prev + 2, dok);
        repeat (20) @(negedge clk);
        assertCount++; if (!dok || doneCount - prev !== 2) begin failCount++; $display("[TB] FAIL break_done_count: got %0d expected 2", doneCount - prev); end
    endtask

    task automatic test_flush();
        int pc, prev, fall, lows;
        logic [15:0] bits;
        bit ok;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop_len = 2'd0;
        prev = doneCount;
        fork
            captureFrame(10, bits, fall, ok);
            begin
                pushWord(9'h055, pc);
                pushWord(9'h066, pc);
                pushWord(9'h077, pc);
                repeat (40) @(negedge clk);
                assertCount++; if (fifo_count !== CW'(2)) begin failCount++; $display("[TB] FAIL flush_pre_count: got %0d expected 2", fifo_count); end
                @(negedge clk);
                flush = 1'b1; s_valid = 1'b1; s_data = 9'h099;
                @(negedge clk);
                flush = 1'b0; s_valid = 1'b0;
                assertCount++; if (fifo_count !== '0 || fifo_empty !== 1'b1) begin failCount++; $display("[TB] FAIL flush_count: count %0d empty %b expected 0 1", fifo_count, fifo_empty); end
            end
        join
        assertCount++; if (!ok || bits !== 16'h02AA) begin failCount++; $display("[TB] FAIL flush_frame: got %h expected 02aa", bits); end
        quietLows(400, lows);
        assertCount++; if (lows !== 0) begin failCount++; $display("[TB] FAIL flush_no_more: got %0d low samples expected 0", lows); end
        assertCount++; if (doneCount - prev !== 1) begin failCount++; $display("[TB] FAIL flush_done_count: got %0d expected 1", doneCount - prev); end
    endtask

    task automatic test_async_reset();
        int pc, prev, lows;
        cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop_len = 2'd0;
        prev = doneCount;
        pushWord(9'h011, pc);
        pushWord(9'h022, pc);
        pushWord(9'h033, pc);
        pushWord(9'h044, pc);
        repeat (60) @(negedge clk);
        assertCount++; if (fifo_count !== CW'(3) || tx_busy !== 1'b1) begin failCount++; $display("[TB] FAIL rst_pre: count %0d busy %b expected 3 1", fifo_count, tx_busy); end
        #2 rst = 1'b1;
        #1;
        assertCount++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_line: txd %b busy %b expected 1 0", uart_txd, tx_busy); end
        assertCount++; if (fifo_count !== '0 || fifo_empty !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_fifo: count %0d empty %b expected 0 1", fifo_count, fifo_empty); end
        @(negedge clk);
        rst = 1'b0;
        quietLows(400, lows);
        assertCount++; if (lows !== 0 || doneCount - prev !== 0) begin failCount++; $display("[TB] FAIL rst_no_frame: lows %0d dones %0d expected 0 0", lows, doneCount - prev); end
    endtask

    initial begin
        test_reset();
        test_8e2();
        repeat (20) @(negedge clk);
        test_5o15();
        repeat (20) @(negedge clk);
        test_slow_tick();
        test_fifo_fill();
        repeat (20) @(negedge clk);
        test_break();
        repeat (20) @(negedge clk);
        test_flush();
        repeat (20) @(negedge clk);
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
